// File: rtl/vga_scan_renderer.sv
// VGA scan generator for the snake display: pixel counters, entity-to-colour mapping
// aligned to the game logic's return latency, and the frame-paced movement tick.
module vga_scan_renderer #(
  parameter int          ENT_LATENCY   = 1,
  parameter int          UPDATE_FRAMES = 8,
  parameter logic [11:0] COL_BG        = 12'h000,
  parameter logic [11:0] COL_HEAD      = 12'h0F0,
  parameter logic [11:0] COL_TAIL      = 12'h080,
  parameter logic [11:0] COL_APPLE     = 12'hF00,
  parameter logic [11:0] COL_OVER      = 12'h400,
  parameter logic [11:0] COL_WON       = 12'h040,
  parameter int          H_VISIBLE     = 640,
  parameter int          H_FRONT       = 16,
  parameter int          H_SYNC        = 96,
  parameter int          H_BACK        = 48,
  parameter int          V_VISIBLE     = 480,
  parameter int          V_FRONT       = 10,
  parameter int          V_SYNC        = 2,
  parameter int          V_BACK        = 33
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [1:0]  entity,
  input  logic        game_over,
  input  logic        game_won,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        update_tick
);

  // Entity codes returned by the game logic; 2'd0 is "nothing".
  localparam logic [1:0] ENT_HEAD  = 2'd1;
  localparam logic [1:0] ENT_TAIL  = 2'd2;
  localparam logic [1:0] ENT_APPLE = 2'd3;

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [7:0] FC_LAST  = 8'(UPDATE_FRAMES - 1);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } scan_t;

  localparam scan_t SCAN_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

  scan_t       raw;
  scan_t       pipe [ENT_LATENCY];
  scan_t       ent_scan;
  logic [7:0]  fc;
  logic [11:0] bg_col;
  logic [11:0] pix_col;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_out <= '0;
      y_out <= '0;
    end else if (x_out == H_LAST) begin
      x_out <= '0;
      y_out <= (y_out == V_LAST) ? 10'd0 : y_out + 10'd1;
    end else begin
      x_out <= x_out + 10'd1;
    end
  end

  always_comb begin
    raw.act = (x_out < H_VIS) && (y_out < V_VIS);
    raw.hs  = !((x_out >= HS_FIRST) && (x_out <= HS_LAST));
    raw.vs  = !((y_out >= VS_FIRST) && (y_out <= VS_LAST));
  end

  // Delay the scan qualifiers so they line up with the entity code for the same pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENT_LATENCY; i++) pipe[i] <= SCAN_IDLE;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < ENT_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ent_scan = pipe[ENT_LATENCY-1];

  always_comb begin
    bg_col  = game_won ? COL_WON : (game_over ? COL_OVER : COL_BG);
    pix_col = bg_col;
    case (entity)
      ENT_HEAD:  pix_col = COL_HEAD;
      ENT_TAIL:  pix_col = COL_TAIL;
      ENT_APPLE: pix_col = COL_APPLE;
      default:   ;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= ent_scan.act ? pix_col : 12'h000;
      hsync <= ent_scan.hs;
      vsync <= ent_scan.vs;
    end
  end

  // Frame count advances at the first pixel of vertical blanking.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      fc          <= '0;
      update_tick <= 1'b0;
    end else if ((x_out == 10'd0) && (y_out == V_VIS)) begin
      if (fc == FC_LAST) begin
        fc          <= '0;
        update_tick <= 1'b1;
      end else begin
        fc          <= fc + 8'd1;
        update_tick <= 1'b0;
      end
    end else begin
      update_tick <= 1'b0;
    end
  end

endmodule
